// File: rtl/sync_fifo_pro.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// optional first-word-fall-through read, sticky error flags and synchronous flush.
module sync_fifo_pro #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned FWFT      = 0,
    parameter int unsigned AFULL_TH  = DEPTH - 2,
    parameter int unsigned AEMPTY_TH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cs,
    input  logic                     flush,
    input  logic                     wr_enb,
    input  logic                     rd_enb,
    input  logic [WIDTH-1:0]         data_in,
    output logic [WIDTH-1:0]         data_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr, count_q;
    logic [PW-1:0]    wr_ptr_d, rd_ptr_d, count_d;
    logic             overflow_d, underflow_d;
    logic             rd_acc, wr_acc;

    // Status decodes from the registered count only
    assign count        = count_q;
    assign full         = (count_q == PW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= PW'(AFULL_TH));
    assign almost_empty = (count_q <= PW'(AEMPTY_TH));

    // A write into a full FIFO still lands when a read frees a slot this cycle
    assign rd_acc = cs & rd_enb & ~empty;
    assign wr_acc = cs & wr_enb & (~full | rd_acc);

    always_comb begin
        wr_ptr_d    = wr_ptr;
        rd_ptr_d    = rd_ptr;
        count_d     = count_q;
        overflow_d  = overflow;
        underflow_d = underflow;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr + PW'(1);
            if (rd_acc) rd_ptr_d = rd_ptr + PW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + PW'(1);
                2'b01:   count_d = count_q - PW'(1);
                default: count_d = count_q;
            endcase
            if (cs & wr_enb & ~wr_acc) overflow_d  = 1'b1;
            if (cs & rd_enb & empty)   underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_d;
            rd_ptr    <= rd_ptr_d;
            count_q   <= count_d;
            overflow  <= overflow_d;
            underflow <= underflow_d;
        end
    end

    // Storage array carries no reset; contents are only meaningful below count
    always_ff @(posedge clk) begin
        if (wr_acc && !flush) mem[wr_ptr[AW-1:0]] <= data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = empty ? '0 : mem[rd_ptr[AW-1:0]];
        end else begin : g_std
            logic [WIDTH-1:0] dout_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)        dout_q <= '0;
                else if (flush)  dout_q <= '0;
                else if (rd_acc) dout_q <= mem[rd_ptr[AW-1:0]];
            end
            assign data_out = dout_q;
        end
    endgenerate

    // Wrap-bit pointer difference must always agree with the count register
    ptr_count_consistent: assert property (@(posedge clk) disable iff (!rst)
        count_q == PW'(wr_ptr - rd_ptr));

endmodule

// File: doc/sync_fifo_pro.md
# sync_fifo_pro

Parametrised single-clock FIFO, the next generation of the team's synchronous FIFO. It adds:
- an occupancy count and programmable almost-full/almost-empty thresholds;
- an optional first-word-fall-through (FWFT) read mode;
- write-through-full when a read is accepted in the same cycle;
- sticky overflow/underflow error flags and a synchronous flush.

It sits between producer and consumer datapaths in the same clock domain.

## Interface
- WIDTH, 8, data word width (≥1)
- DEPTH, 32, number of entries; power of two, ≥4
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- AFULL_TH, DEPTH-2, almost_full asserts when count ≥ AFULL_TH (1..DEPTH)
- AEMPTY_TH, 2, almost_empty asserts when count ≤ AEMPTY_TH (0..DEPTH-1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- cs  in  1  chip select; gates wr_enb and rd_enb (not flush)
- flush  in  1  synchronous clear of contents and error flags
- wr_enb  in  1  write request
- rd_enb  in  1  read request (pop in both modes)
- data_in  in  WIDTH  write data
- data_out  out  WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AFULL_TH
- almost_empty  out  1  count ≤ AEMPTY_TH
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write rejected
- underflow  out  1  sticky: read rejected

## Operation
- Pointers wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits. Address = low bits; MSB is the wrap bit. Both increment modulo 2·DEPTH.
- count is a register:
  - +1 on accepted write only;
  - −1 on accepted read only;
  - unchanged on both or neither.
- full, empty, almost_full and almost_empty decode combinationally from the registered count.
- rd_acc = cs & rd_enb & !empty.
- wr_acc = cs & wr_enb & (!full | rd_acc).
  - A write while full is accepted if a read is accepted in the same cycle; count stays DEPTH.
  - A write while empty with a simultaneous read: only the write is accepted (read rejected, count becomes 1).
- overflow sets on cs & wr_enb & !wr_acc. underflow sets on cs & rd_enb & empty. Both hold until flush or reset.
- Standard mode (FWFT=0): on rd_acc, data_out is loaded with mem[rd_ptr] at that edge. Otherwise data_out holds its value.
- FWFT mode (FWFT=1): data_out = mem[rd_ptr] combinationally while !empty, and 0 while empty. rd_acc advances to the next word.
- flush (priority over rd/wr in the same cycle) clears:
  - pointers, count, overflow and underflow;
  - data_out, to 0.

  Memory contents are not cleared.
- Reset values (rst low, asynchronous):
  - pointers, count and data_out = 0;
  - empty = 1, full = 0, overflow = 0, underflow = 0;
  - almost_empty = 1, almost_full = 0.
- Reset mid-operation discards all contents immediately. No memory reset is required.

## Timing
- Write latency: data accepted at edge N is readable from edge N+1.
  - empty deasserts after edge N.
  - FWFT: data_out valid in the same cycle.
  - Standard: the first rd_acc is possible at edge N+1, and data_out is valid after that edge.
- Read latency (standard): 1 cycle from rd_acc edge to data_out.
- Flags and count reflect all accepted operations one edge after they are sampled. There are no combinational paths from wr_enb/rd_enb to the flags.
- Back-to-back reads and writes are sustained at 1 word/cycle each, indefinitely, with correct wrap at every DEPTH boundary.

## Test plan
- Reset, then write 0x01..0x20 (32 words):
  - full=1, count=32, almost_full from count=30;
  - a 33rd write sets overflow=1 and count stays 32.
- From full, read all 32 words (standard mode): data_out = 0x01..0x20 in order, each one cycle after its rd_acc. empty=1 at the end. An extra read sets underflow=1.
- Full FIFO with wr_enb=rd_enb=1 and data 0xA5: read returns the oldest word, write is accepted, count stays 32, overflow stays 0. 0xA5 emerges after 32 further reads.
- FWFT=1, empty FIFO, write 0x3C: the next cycle has empty=0 and data_out=0x3C without rd_enb. After rd_enb, data_out=0 and empty=1.
- Write 5 words, assert flush together with wr_enb: count=0, empty=1, overflow/underflow cleared, data_out=0, and the write is ignored.
- Write 10 words, pulse rst low mid-stream: all outputs go to reset values asynchronously. After release, wrap test passes: 100 random interleaved ops match a reference queue model.
